input_conditioner: RTL and testbench



---
 rtl/input_cond_pkg.sv | 16 +
 rtl/debounce_bit.sv | 109 ++++++++++
 rtl/input_conditioner.sv | 68 ++++++
 tb/tb_input_conditioner.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_cond_pkg.sv
// Shared types and constants for the switch/button input conditioner.
package input_cond_pkg;

    // Production settle time: 10 ms at 50 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Short settle time so simulations finish in a few cycles.
    localparam int unsigned SIM_DEBOUNCE_CYCLES = 4;

    // Per-channel debounce state.
    typedef enum logic {
        STABLE  = 1'b0,
        PENDING = 1'b1
    } deb_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One conditioned channel: 2-flop synchronizer, debounce FSM with settle
// counter, and registered rise/fall pulses on each accepted level change.
module debounce_bit
    import input_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = SIM_DEBOUNCE_CYCLES,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES),
    parameter bit          SYNC_RST        = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned LAST = DEBOUNCE_CYCLES - 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LAST);

    logic             sync_q1;
    logic             sync;
    deb_state_e       state;
    deb_state_e       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             stable;
    logic             stable_next;
    logic             rise_next;
    logic             fall_next;
    logic             accept;

    // Bring the asynchronous pin into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= SYNC_RST;
            sync    <= SYNC_RST;
        end else begin
            sync_q1 <= raw;
            sync    <= sync_q1;
        end
    end

    // State register: FSM state, settle counter, accepted level and pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= STABLE;
            cnt    <= '0;
            stable <= SYNC_RST;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            stable <= stable_next;
            rise   <= rise_next;
            fall   <= fall_next;
        end
    end

    // Next state: count consecutive mismatching samples, drop back on any match.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        unique case (state)
            STABLE: begin
                cnt_next = '0;
                if (sync != stable) begin
                    state_next = PENDING;
                    cnt_next   = CNT_W'(1);
                end
            end
            PENDING: begin
                if (sync == stable) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else if (cnt == LAST_CNT) begin
                    state_next = STABLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = STABLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs: take the new level and fire a one-cycle pulse once the count completes.
    always_comb begin
        accept      = 1'b0;
        stable_next = stable;
        rise_next   = 1'b0;
        fall_next   = 1'b0;
        if ((state == PENDING) && (sync != stable) && (cnt == LAST_CNT)) begin
            accept = 1'b1;
        end
        if (accept) begin
            stable_next = sync;
            rise_next   = sync;
            fall_next   = ~sync;
        end
    end

    assign level = stable;

endmodule

// File: rtl/input_conditioner.sv
// Board input front end: debounces slide switches and push-buttons and
// presents clean levels plus one-cycle change/press/release pulses.
module input_conditioner
    import input_cond_pkg::*;
#(
    parameter int unsigned SW_W            = 10,
    parameter int unsigned KEY_W           = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic             MAX10_CLK1_50,
    input  logic             RST_N,
    input  logic [SW_W-1:0]  SW_IN,
    input  logic [KEY_W-1:0] KEY_IN,
    output logic [SW_W-1:0]  SW_OUT,
    output logic             SW_CHANGED,
    output logic [KEY_W-1:0] KEY_OUT,
    output logic [KEY_W-1:0] KEY_PRESS,
    output logic [KEY_W-1:0] KEY_RELEASE
);

    logic [SW_W-1:0]  sw_rise;
    logic [SW_W-1:0]  sw_fall;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_rise;
    logic [KEY_W-1:0] key_fall;

    // Switch channels: active-high, idle low out of reset.
    for (genvar gi = 0; gi < SW_W; gi++) begin : g_sw
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_RST        (1'b0)
        ) u_bit (
            .clk   (MAX10_CLK1_50),
            .rst_n (RST_N),
            .raw   (SW_IN[gi]),
            .level (SW_OUT[gi]),
            .rise  (sw_rise[gi]),
            .fall  (sw_fall[gi])
        );
    end

    // Button channels: active-low pins, so the synchronizers idle high (released).
    for (genvar gk = 0; gk < KEY_W; gk++) begin : g_key
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W),
            .SYNC_RST        (1'b1)
        ) u_bit (
            .clk   (MAX10_CLK1_50),
            .rst_n (RST_N),
            .raw   (KEY_IN[gk]),
            .level (key_level[gk]),
            .rise  (key_rise[gk]),
            .fall  (key_fall[gk])
        );
    end

    // Pin low means pressed, so a falling pin level is a press.
    assign KEY_OUT     = ~key_level;
    assign KEY_PRESS   = key_fall;
    assign KEY_RELEASE = key_rise;

    // Any switch update in this cycle collapses into one change pulse.
    assign SW_CHANGED  = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random toggling,
// every cycle compared against a sample-window reference model.
module tb_input_conditioner;
    import input_cond_pkg::*;

    localparam int unsigned SW_W  = 10;
    localparam int unsigned KEY_W = 2;
    localparam int unsigned D     = SIM_DEBOUNCE_CYCLES;
    localparam int unsigned NCH   = SW_W + KEY_W;
    localparam logic [NCH-1:0] RST_VAL = {{KEY_W{1'b1}}, {SW_W{1'b0}}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic [SW_W-1:0]  sw_in;
    logic [KEY_W-1:0] key_in;
    logic [SW_W-1:0]  sw_out;
    logic             sw_changed;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;

    int checks = 0;
    int errors = 0;

    // Reference model: raw pins reach the debouncer two edges late; a channel
    // takes a new level when its last D samples all disagree with the held level.
    logic [NCH-1:0]   m_d1;
    logic [NCH-1:0]   m_d2;
    logic [NCH-1:0]   m_stable;
    logic [NCH-1:0]   m_win [D];
    logic [SW_W-1:0]  e_sw_out;
    logic             e_sw_changed;
    logic [KEY_W-1:0] e_key_out;
    logic [KEY_W-1:0] e_press;
    logic [KEY_W-1:0] e_release;

    input_conditioner #(
        .SW_W            (SW_W),
        .KEY_W           (KEY_W),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .RST_N         (rst_n),
        .SW_IN         (sw_in),
        .KEY_IN        (key_in),
        .SW_OUT        (sw_out),
        .SW_CHANGED    (sw_changed),
        .KEY_OUT       (key_out),
        .KEY_PRESS     (key_press),
        .KEY_RELEASE   (key_release)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NCH-1:0] smp;
        logic [NCH-1:0] acc;
        logic [NCH-1:0] nstable;
        if (!rst_n) begin
            m_d1 = RST_VAL;
            m_d2 = RST_VAL;
            for (int i = 0; i < int'(D); i++) m_win[i] = RST_VAL;
            acc     = '0;
            nstable = RST_VAL;
        end else begin
            smp  = m_d2;
            m_d2 = m_d1;
            m_d1 = {key_in, sw_in};
            for (int i = int'(D) - 1; i > 0; i--) m_win[i] = m_win[i-1];
            m_win[0] = smp;
            acc = '1;
            for (int i = 0; i < int'(D); i++) acc = acc & (m_win[i] ^ m_stable);
            nstable = m_stable ^ acc;
        end
        e_sw_out     = nstable[SW_W-1:0];
        e_key_out    = ~nstable[NCH-1:SW_W];
        e_sw_changed = |acc[SW_W-1:0];
        e_press      = acc[NCH-1:SW_W] & e_key_out;
        e_release    = acc[NCH-1:SW_W] & ~e_key_out;
        m_stable     = nstable;
    endtask

    // One clock: advance model on the edge, compare just after it.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        chk("model_sw_out",      32'(sw_out),      32'(e_sw_out));
        chk("model_sw_changed",  32'(sw_changed),  32'(e_sw_changed));
        chk("model_key_out",     32'(key_out),     32'(e_key_out));
        chk("model_key_press",   32'(key_press),   32'(e_press));
        chk("model_key_release", 32'(key_release), 32'(e_release));
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        int pulses;
        logic [NCH-1:0] raw;

        // Reset with switches on and buttons held.
        rst_n  = 1'b0;
        sw_in  = 10'h3FF;
        key_in = 2'b00;
        cycn(3);
        chk("rst_sw_out",      32'(sw_out),      32'h0);
        chk("rst_key_out",     32'(key_out),     32'h0);
        chk("rst_sw_changed",  32'(sw_changed),  32'h0);
        chk("rst_key_press",   32'(key_press),   32'h0);
        chk("rst_key_release", 32'(key_release), 32'h0);
        rst_n = 1'b1;
        cycn(5);
        chk("rel_e5_sw_out",   32'(sw_out),      32'h0);
        cyc();
        chk("rel_e6_sw_out",     32'(sw_out),     32'h3FF);
        chk("rel_e6_key_out",    32'(key_out),    32'h3);
        chk("rel_e6_key_press",  32'(key_press),  32'h3);
        chk("rel_e6_sw_changed", 32'(sw_changed), 32'h1);
        cyc();
        chk("rel_e7_sw_changed", 32'(sw_changed), 32'h0);
        chk("rel_e7_key_press",  32'(key_press),  32'h0);

        // Idle everything, then a clean press on button 0.
        sw_in  = 10'h000;
        key_in = 2'b11;
        cycn(10);
        key_in = 2'b10;
        cycn(5);
        chk("press_e5_key_out", 32'(key_out), 32'h0);
        cyc();
        chk("press_e6_key_out",     32'(key_out),     32'h1);
        chk("press_e6_key_press",   32'(key_press),   32'h1);
        chk("press_e6_key_release", 32'(key_release), 32'h0);
        cyc();
        chk("press_e7_key_press", 32'(key_press), 32'h0);

        // Short bounces on button 1 and switch 4 must be rejected.
        for (int k = 0; k < 14; k++) begin
            key_in[1] = (k < 3) ? 1'b0 : 1'b1;
            sw_in[4]  = (k < 10) ? k[1] : 1'b0;
            cyc();
            chk("bounce_key_out",  32'(key_out),                   32'h1);
            chk("bounce_sw_out",   32'(sw_out),                    32'h0);
            chk("bounce_pulses",   32'({sw_changed, key_press, key_release}), 32'h0);
        end

        // Whole switch word changes in one step.
        sw_in = 10'h2A5;
        cycn(5);
        chk("word_e5_sw_out", 32'(sw_out), 32'h0);
        cyc();
        chk("word_e6_sw_out",     32'(sw_out),     32'h2A5);
        chk("word_e6_sw_changed", 32'(sw_changed), 32'h1);
        cyc();
        chk("word_e7_sw_changed", 32'(sw_changed), 32'h0);

        // Switch bits changing two cycles apart produce two change pulses.
        sw_in = 10'h000;
        cycn(10);
        sw_in[0] = 1'b1;
        pulses = 0;
        for (int k = 0; k < 14; k++) begin
            if (k == 2) sw_in[1] = 1'b1;
            cyc();
            pulses += int'(sw_changed);
        end
        chk("stagger_pulse_count", 32'(pulses), 32'd2);
        chk("stagger_sw_out",      32'(sw_out), 32'h3);

        // Press one button and release the other on the same edge.
        key_in = 2'b01;
        cycn(10);
        chk("simul_pre_key_out", 32'(key_out), 32'h2);
        key_in = 2'b10;
        cycn(5);
        cyc();
        chk("simul_key_press",   32'(key_press),   32'h1);
        chk("simul_key_release", 32'(key_release), 32'h2);
        chk("simul_key_out",     32'(key_out),     32'h1);

        // Reset after two counted cycles of a switch change.
        sw_in = 10'h000;
        cycn(10);
        sw_in[0] = 1'b1;
        cycn(4);
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("midrst_sw_out", 32'(sw_out),     32'h0);
            chk("midrst_pulse",  32'(sw_changed), 32'h0);
        end
        rst_n = 1'b1;
        cycn(5);
        chk("midrst_e5_sw_out", 32'(sw_out), 32'h0);
        cyc();
        chk("midrst_e6_sw_out",     32'(sw_out),     32'h1);
        chk("midrst_e6_sw_changed", 32'(sw_changed), 32'h1);

        // Random toggling, concentrated on a few channels to provoke bounces.
        for (int k = 0; k < 600; k++) begin
            raw = {key_in, sw_in};
            if ($urandom_range(0, 2) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    raw[$urandom_range(0, 3)] ^= 1'b1;
                else
                    raw[$urandom_range(0, NCH - 1)] ^= 1'b1;
            end
            {key_in, sw_in} = raw;
            rst_n = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
